// File: rtl/maj_pkg.sv
// Shared types and limits for the majority-vote filter.
// FSM state enum, parameter legality bounds and vote threshold helper.
package maj_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int N_MIN    = 3;
  localparam int N_MAX    = 15;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;

  // Votes needed for a strict majority of n channels.
  function automatic int maj_thresh(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/maj_popcount.sv
// Combinational vote counter: majority bit and unanimity flag.
// Purely combinational; parametrised by channel count N.
module maj_popcount
  import maj_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] din,
  output logic         maj,
  output logic         unanimous
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] THR = CW'(maj_thresh(N));

  logic [CW-1:0] ones;

  // Count set votes across all channels.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(din[i]);
    end
  end

  assign maj       = (ones >= THR);
  assign unanimous = (din == '0) || (din == '1);

endmodule

// File: rtl/maj_vote_filter.sv
// N-channel majority voter with HOLD-sample debounce and fault flags.
// Optional disagreement counter port dis_cnt: define MAJ_DISAGREE_CNT_EN.
module maj_vote_filter
  import maj_pkg::*;
#(
  parameter int N     = 3,
  parameter int HOLD  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     din,
  output logic             raw_vote,
  output logic             vote,
  output logic             out_valid,
  output logic             pending,
  output logic [N-1:0]     fault
`ifdef MAJ_DISAGREE_CNT_EN
  ,
  output logic [CNT_W-1:0] dis_cnt
`endif
);

  if ((N < N_MIN) || (N > N_MAX) || ((N % 2) == 0)) begin : g_bad_n
    $error("maj_vote_filter: N must be odd and within 3..15");
  end

  if ((HOLD < HOLD_MIN) || (HOLD > HOLD_MAX)) begin : g_bad_hold
    $error("maj_vote_filter: HOLD must be within 1..255");
  end

  localparam logic [7:0] HOLD_Q = 8'(HOLD);
  localparam bit         HOLD1  = (HOLD == 1);

  logic       maj;
  logic       unan;
  state_t     state;
  state_t     state_nx;
  logic [7:0] qcnt;
  logic [7:0] qcnt_nx;
  logic       vote_nx;

  maj_popcount #(
    .N(N)
  ) u_pop (
    .din      (din),
    .maj      (maj),
    .unanimous(unan)
  );

  // Unfiltered vote, output strobe and sticky per-channel fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_vote  <= 1'b0;
      out_valid <= 1'b0;
      fault     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        raw_vote <= maj;
        fault    <= fault | (din ^ {N{maj}});
      end
    end
  end

  // Debounce FSM state, qualify counter and filtered vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      qcnt  <= '0;
      vote  <= 1'b0;
    end else begin
      state <= state_nx;
      qcnt  <= qcnt_nx;
      vote  <= vote_nx;
    end
  end

  // Next state: a flip needs HOLD consecutive disagreeing valid samples.
  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    vote_nx  = vote;
    if (in_valid) begin
      unique case (state)
        STABLE: begin
          if (maj != vote) begin
            if (HOLD1) begin
              vote_nx = ~vote;
            end else begin
              qcnt_nx  = 8'd1;
              state_nx = PENDING;
            end
          end
        end
        PENDING: begin
          if (maj == vote) begin
            qcnt_nx  = '0;
            state_nx = STABLE;
          end else if (qcnt + 8'd1 == HOLD_Q) begin
            vote_nx  = ~vote;
            qcnt_nx  = '0;
            state_nx = STABLE;
          end else begin
            qcnt_nx = qcnt + 8'd1;
          end
        end
        default: begin
          state_nx = STABLE;
          qcnt_nx  = '0;
        end
      endcase
    end
  end

  assign pending = (state == PENDING);

`ifdef MAJ_DISAGREE_CNT_EN
  // Saturating count of valid samples that were not unanimous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dis_cnt <= '0;
    end else if (in_valid && !unan && (dis_cnt != '1)) begin
      dis_cnt <= dis_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_unan;
  assign unused_unan = unan;
`endif

endmodule

// File: doc/maj_vote_filter.md
MAJ_VOTE_FILTER -- requirements
Module: maj_vote_filter

Interface
REQ-001 SHALL have parameter N, default 3: voter channel count; odd, 3..15; even or out-of-range values are an elaboration error.
REQ-002 SHALL have parameter HOLD, default 4: consecutive agreeing valid samples required before the output flips; range 1..255.
REQ-003 SHALL have parameter CNT_W, default 16: width of the disagreement counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  din is sampled this cycle.
REQ-007 SHALL have port din  input  N  one vote bit per channel.
REQ-008 SHALL have port raw_vote  output  1  registered unfiltered majority of the last valid sample.
REQ-009 SHALL have port vote  output  1  filtered (debounced) majority.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse, one cycle after each accepted in_valid.
REQ-011 SHALL have port pending  output  1  high while a flip candidate is being qualified.
REQ-012 SHALL have port fault  output  N  sticky flags: the channel disagreed with the majority at least once.
REQ-013 SHALL have port dis_cnt  output  CNT_W  count of non-unanimous samples; present only per REQ-027.

Function
REQ-014 SHALL compute majority as popcount(din) >= (N+1)/2; the result is registered into raw_vote on valid cycles only.
REQ-015 SHALL have latency 1: a sample taken at edge k updates raw_vote, fault and out_valid at edge k+1; vote updates no earlier than edge k+1.
REQ-016 SHALL hold all outputs except out_valid, and all state, when in_valid=0; out_valid is 0 in such cycles.
REQ-017 SHALL implement FSM states STABLE and PENDING plus a qualify counter qcnt (8 bits).
REQ-018 SHALL, in STABLE with a valid sample whose majority != vote: if HOLD=1, flip vote at the same edge and stay STABLE; otherwise set qcnt=1 and go to PENDING.
REQ-019 SHALL, in PENDING with a valid sample whose majority != vote: increment qcnt; when qcnt reaches HOLD, flip vote, clear qcnt and go to STABLE.
REQ-020 SHALL, in PENDING with a valid sample whose majority == vote: clear qcnt and return to STABLE without flipping.
REQ-021 SHALL leave the FSM unchanged in any state on a cycle with in_valid=0; gaps neither abort nor advance qualification.
REQ-022 SHALL drive pending=1 exactly when the state is PENDING.
REQ-023 SHALL set fault[i] on any valid sample where din[i] != majority; the flags clear only on reset.
REQ-024 SHALL saturate dis_cnt at all-ones; it increments on valid samples that are neither all-0 nor all-1.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force raw_vote=0, vote=0, out_valid=0, pending=0, fault=0, dis_cnt=0, qcnt=0 and state STABLE, including mid-qualification.
REQ-026 SHALL accept a sample on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile port dis_cnt and its counter when macro MAJ_DISAGREE_CNT_EN is defined; without it, neither the port nor the counter exists and all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum (STABLE, PENDING) and the N/HOLD legality limits in shared package maj_pkg.
REQ-029 SHALL use one combinational sub-module, maj_popcount, parametrised by N, returning the majority bit and an unanimous flag.

Verification
REQ-030 SHALL check N=3: din=011 with valid -> raw_vote=1 and out_valid=1 next cycle; fault[2]=1.
REQ-031 SHALL check HOLD=4: four consecutive valid samples of 111 from vote=0 -> vote=1 on the fourth sample's edge; pending high for 3 cycles before it.
REQ-032 SHALL check HOLD=4: samples 111,111,000 -> pending drops and vote stays 0; fault stays 0.
REQ-033 SHALL check HOLD=3 with in_valid gaps between 111 samples -> vote flips only after the third valid sample; the gaps change nothing.
REQ-034 SHALL check rst_n pulsed low while pending=1 -> all outputs 0 immediately, state STABLE, no clock edge required.
REQ-035 SHALL check N=5 with MAJ_DISAGREE_CNT_EN and CNT_W=2: five samples of 11010 -> dis_cnt saturates at 3; fault=00101.
